id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. Sits directly downstream of the opcode control decoder and the register file.
- Latches the decoded control bundle (RegDs, Branch, MRead, MtoR, AOp, MWrite, ALUsrc, Urw) together with the operand data for the EX stage.
- Contains the load-use hazard detector that stalls IF/ID and inserts bubbles.
- Implements flush on a taken branch, hold on downstream back-pressure, and a saturating stall-cycle counter.

Parameters:
- DATA_W, 32, operand/PC/immediate width
- REG_W, 5, register-address width
- AOP_W, 3, ALU-op code width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid_i  in  1  ID stage holds a real instruction
- RegDs_i, Branch_i, MRead_i, MtoR_i, MWrite_i, ALUsrc_i, Urw_i  in  1 each  decoder control bits
- AOp_i  in  AOP_W  decoder ALU op
- pc4_i  in  DATA_W  PC+4 of ID instruction
- rs_data_i, rt_data_i  in  DATA_W  register file read data
- imm_i  in  DATA_W  sign-extended immediate
- rs_i, rt_i, rd_i  in  REG_W  register fields
- flush_i  in  1  branch taken in EX/MEM; kill ID/EX contents
- hold_i  in  1  downstream back-pressure; freeze ID/EX
- stall_o  out  1  freeze PC and IF/ID this cycle
- ex_valid_o  out  1  EX stage holds a real instruction
- RegDs_o, Branch_o, MRead_o, MtoR_o, MWrite_o, ALUsrc_o, Urw_o  out  1 each  registered control
- AOp_o  out  AOP_W  registered ALU op
- pc4_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data
- rs_o, rt_o, rd_o  out  REG_W  registered fields
- stall_cnt_o  out  CNT_W  cycles with load-use stall asserted, saturating

Behaviour:
- All outputs registered except stall_o, which is combinational. Latency is 1 cycle, ID to EX.
- Reset (rst_n=0 at a clk edge): every registered output is 0, including ex_valid_o and stall_cnt_o. Reset overrides all other inputs. If reset is asserted mid-operation, in-flight content is discarded.
- load_use (combinational) = ex_valid_o & MRead_o & (rt_o != 0) & id_valid_i & ((rt_o == rs_i) | ((rt_o == rt_i) & uses_rt)).
  - uses_rt = RegDs_i | MWrite_i | Branch_i.
- stall_o = hold_i | (load_use & ~flush_i).
- Per-edge update priority, highest first:
  1. reset.
  2. flush_i=1: load a bubble, even if hold_i=1.
  3. hold_i=1: all registers keep their value.
  4. load_use=1: load a bubble.
  5. Otherwise capture inputs, with ex_valid_o <= id_valid_i.
- Bubble: ex_valid_o=0; all control outputs 0, AOp_o=0. Data and field registers may keep their old value but must not be X.
- Capture with id_valid_i=0: same as a bubble for control; data is don't-care.
- X sanitisation on capture: the decoder drives X on don't-care bits. Any control input that is X/Z is stored as 0. Additionally, when Urw_i=0, RegDs_o and MtoR_o are stored as 0. No X may reach an output after reset.
- stall_cnt_o increments by 1 on each edge where load_use & ~flush_i & ~hold_i. It saturates at all-ones and never wraps.
- Load-use stalls last exactly 1 cycle. After the bubble, ex_valid_o=0, so load_use deasserts and the held ID instruction is captured on the next edge.
- Simultaneous flush_i and load_use: flush wins, stall_o follows hold_i only, and the counter does not increment.

Decomposition:
- Shared package core_pkg:
  - AOp encoding constants: LW=000, BEQ=001, RTYPE=010, ADDI=011, SLTI=100, ANDI=101, ORI=110, SW=111.
  - Opcode constants.
  - Packed ctrl_t struct: {RegDs, Branch, MRead, MtoR, AOp, MWrite, ALUsrc, Urw}.
  - Width constants.
- One sub-module, hazard_detect, holds the combinational load_use/stall_o logic. The register bank and counter stay in id_ex_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs -> all outputs 0, stall_cnt_o=0. Release, then ADDI (AOp=011, ALUsrc=1, Urw=1, imm=5) -> next edge ex_valid_o=1, AOp_o=3'b011, imm_o=5.
- Load-use: LW into $8 captured, then ID holds ADD using rs=$8 -> stall_o=1 for 1 cycle, bubble (ex_valid_o=0, all ctrl 0), stall_cnt_o=1. ADD is then captured with RegDs_o=1.
- No false hazard: LW rt=$0 followed by ADD rs=$0 -> stall_o=0. LW rt=$8 followed by ADDI rt=$8 (uses_rt=0, rs=$9) -> stall_o=0.
- Flush priority: flush_i=1 with hold_i=1 and a load_use condition -> next edge bubble, stall_o=hold_i, counter unchanged.
- Hold: hold_i=1 for 3 cycles with changing inputs -> outputs unchanged, stall_o=1, counter unchanged. On release, the current inputs are captured.
- X sanitisation and saturation: SW with RegDs_i=X, MtoR_i=X -> RegDs_o=0, MtoR_o=0, MWrite_o=1, AOp_o=111. Force 70000 load-use stall cycles with CNT_W=16 -> stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, ALU-op and opcode
// encodings, the decoded control bundle and a small input-cleaning helper.
package core_pkg;

  localparam int DATA_W_C = 32;
  localparam int REG_W_C  = 5;
  localparam int AOP_W_C  = 3;
  localparam int CNT_W_C  = 16;

  localparam logic [2:0] AOP_LW    = 3'b000;
  localparam logic [2:0] AOP_BEQ   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_ADDI  = 3'b011;
  localparam logic [2:0] AOP_SLTI  = 3'b100;
  localparam logic [2:0] AOP_ANDI  = 3'b101;
  localparam logic [2:0] AOP_ORI   = 3'b110;
  localparam logic [2:0] AOP_SW    = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic               reg_ds;
    logic               branch;
    logic               mread;
    logic               mtor;
    logic [AOP_W_C-1:0] aop;
    logic               mwrite;
    logic               alusrc;
    logic               urw;
  } ctrl_t;

  // An unknown decoder bit falls to the else branch and is stored as 0.
  function automatic logic clean_bit(input logic b);
    if (b) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load in EX is about to write, and derives the front-end stall.
module hazard_detect
  import core_pkg::*;
#(
  parameter int REG_W = REG_W_C
) (
  input  logic             ex_valid_i,
  input  logic             ex_mread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             reg_ds_i,
  input  logic             mwrite_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             load_use_o,
  output logic             stall_o
);

  logic uses_rt_s;
  logic rt_nonzero_s;

  // A taken-branch flush kills the load-use bubble, so it no longer stalls.
  always_comb begin
    uses_rt_s    = reg_ds_i | mwrite_i | branch_i;
    rt_nonzero_s = (ex_rt_i != {REG_W{1'b0}});
    load_use_o   = ex_valid_i & ex_mread_i & rt_nonzero_s & id_valid_i &
                   ((ex_rt_i == id_rs_i) | ((ex_rt_i == id_rt_i) & uses_rt_s));
    stall_o      = hold_i | (load_use_o & ~flush_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating count of load-use stall cycles.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_C,
  parameter int REG_W  = REG_W_C,
  parameter int AOP_W  = AOP_W_C,
  parameter int CNT_W  = CNT_W_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              RegDs_i,
  input  logic              Branch_i,
  input  logic              MRead_i,
  input  logic              MtoR_i,
  input  logic              MWrite_i,
  input  logic              ALUsrc_i,
  input  logic              Urw_i,
  input  logic [AOP_W-1:0]  AOp_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              RegDs_o,
  output logic              Branch_o,
  output logic              MRead_o,
  output logic              MtoR_o,
  output logic              MWrite_o,
  output logic              ALUsrc_o,
  output logic              Urw_o,
  output logic [AOP_W-1:0]  AOp_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_W-1:0]  rs_o,
  output logic [REG_W-1:0]  rt_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              ex_valid_q, ex_valid_d;
  ctrl_t             ctrl_q, ctrl_d, ctrl_in_s;
  logic [DATA_W-1:0] pc4_q, pc4_d, rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_use_s;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_valid_i (ex_valid_q),
    .ex_mread_i (ctrl_q.mread),
    .ex_rt_i    (rt_q),
    .id_valid_i (id_valid_i),
    .id_rs_i    (rs_i),
    .id_rt_i    (rt_i),
    .reg_ds_i   (RegDs_i),
    .mwrite_i   (MWrite_i),
    .branch_i   (Branch_i),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .load_use_o (load_use_s),
    .stall_o    (stall_o)
  );

  // Clean decoder bits; register write-back selects only matter with Urw set.
  always_comb begin
    ctrl_in_s        = '0;
    ctrl_in_s.reg_ds = clean_bit(RegDs_i) & clean_bit(Urw_i);
    ctrl_in_s.branch = clean_bit(Branch_i);
    ctrl_in_s.mread  = clean_bit(MRead_i);
    ctrl_in_s.mtor   = clean_bit(MtoR_i) & clean_bit(Urw_i);
    for (int i = 0; i < AOP_W; i++) begin
      ctrl_in_s.aop[i] = clean_bit(AOp_i[i]);
    end
    ctrl_in_s.mwrite = clean_bit(MWrite_i);
    ctrl_in_s.alusrc = clean_bit(ALUsrc_i);
    ctrl_in_s.urw    = clean_bit(Urw_i);
  end

  // Next state: flush beats hold, hold beats load-use bubble, else capture.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ctrl_d     = ctrl_q;
    pc4_d      = pc4_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
    end else if (hold_i) begin
      ex_valid_d = ex_valid_q;
    end else if (load_use_s) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
    end else if (id_valid_i) begin
      ex_valid_d = 1'b1;
      ctrl_d     = ctrl_in_s;
      pc4_d      = pc4_i;
      rs_data_d  = rs_data_i;
      rt_data_d  = rt_data_i;
      imm_d      = imm_i;
      rs_d       = rs_i;
      rt_d       = rt_i;
      rd_d       = rd_i;
    end else begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
    end
  end

  // Saturating count of edges that actually insert a load-use bubble.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_s && !flush_i && !hold_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Pipeline register bank and counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ctrl_q      <= '0;
      pc4_q       <= {DATA_W{1'b0}};
      rs_data_q   <= {DATA_W{1'b0}};
      rt_data_q   <= {DATA_W{1'b0}};
      imm_q       <= {DATA_W{1'b0}};
      rs_q        <= {REG_W{1'b0}};
      rt_q        <= {REG_W{1'b0}};
      rd_q        <= {REG_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q  <= ex_valid_d;
      ctrl_q      <= ctrl_d;
      pc4_q       <= pc4_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign RegDs_o     = ctrl_q.reg_ds;
  assign Branch_o    = ctrl_q.branch;
  assign MRead_o     = ctrl_q.mread;
  assign MtoR_o      = ctrl_q.mtor;
  assign AOp_o       = ctrl_q.aop;
  assign MWrite_o    = ctrl_q.mwrite;
  assign ALUsrc_o    = ctrl_q.alusrc;
  assign Urw_o       = ctrl_q.urw;
  assign pc4_o       = pc4_q;
  assign rs_data_o   = rs_data_q;
  assign rt_data_o   = rt_data_q;
  assign imm_o       = imm_q;
  assign rs_o        = rs_q;
  assign rt_o        = rt_q;
  assign rd_o        = rd_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies directed and random
// instructions and queues the expected EX state; a monitor compares each cycle.
module tb_id_ex_stage;

  localparam int TB_CNT_W = 8;
  localparam logic [TB_CNT_W-1:0] CNT_MAX = {TB_CNT_W{1'b1}};

  typedef struct packed {
    logic        rst_n, id_valid, regds, branch, mread, mtor, mwrite, alusrc, urw;
    logic [2:0]  aop;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic        flush, hold;
  } in_t;

  typedef struct packed {
    logic                valid;
    logic [9:0]          ctrl;   // {RegDs,Branch,MRead,MtoR,AOp,MWrite,ALUsrc,Urw}
    logic [31:0]         pc4, rsd, rtd, imm;
    logic [4:0]          rs, rt, rd;
    logic [TB_CNT_W-1:0] cnt;
  } state_t;

  typedef struct packed {
    state_t st;
    logic   stall, stall_chk, data_chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, id_valid_i = 1'b0, flush_i = 1'b0, hold_i = 1'b0;
  logic RegDs_i = 1'b0, Branch_i = 1'b0, MRead_i = 1'b0, MtoR_i = 1'b0;
  logic MWrite_i = 1'b0, ALUsrc_i = 1'b0, Urw_i = 1'b0;
  logic [2:0]  AOp_i = 3'd0;
  logic [31:0] pc4_i = 32'd0, rs_data_i = 32'd0, rt_data_i = 32'd0, imm_i = 32'd0;
  logic [4:0]  rs_i = 5'd0, rt_i = 5'd0, rd_i = 5'd0;

  logic stall_o, ex_valid_o, RegDs_o, Branch_o, MRead_o, MtoR_o, MWrite_o, ALUsrc_o, Urw_o;
  logic [2:0]  AOp_o;
  logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [TB_CNT_W-1:0] stall_cnt_o;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .AOP_W(3), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
    .RegDs_i(RegDs_i), .Branch_i(Branch_i), .MRead_i(MRead_i), .MtoR_i(MtoR_i),
    .MWrite_i(MWrite_i), .ALUsrc_i(ALUsrc_i), .Urw_i(Urw_i), .AOp_i(AOp_i),
    .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o),
    .RegDs_o(RegDs_o), .Branch_o(Branch_o), .MRead_o(MRead_o), .MtoR_o(MtoR_o),
    .MWrite_o(MWrite_o), .ALUsrc_o(ALUsrc_o), .Urw_o(Urw_o), .AOp_o(AOp_o),
    .pc4_o(pc4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .stall_cnt_o(stall_cnt_o)
  );

  int     vectors = 0;
  int     miscompares = 0;
  exp_t   exp_q[$];
  state_t model_st = '0;
  logic   model_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is1(input logic b);
    return (b === 1'b1);
  endfunction

  // Reference: what the EX stage should hold after the coming edge.
  function automatic exp_t predict(input state_t s, input logic known, input in_t v);
    exp_t e;
    logic uses_rt, hazard, fl, hd;
    fl = is1(v.flush);
    hd = is1(v.hold);
    uses_rt = is1(v.regds) | is1(v.mwrite) | is1(v.branch);
    hazard = known && s.valid && s.ctrl[7] && (s.rt != 5'd0) && is1(v.id_valid) &&
             ((s.rt == v.rs) || ((s.rt == v.rt) && uses_rt));
    e.stall     = hd | (hazard & ~fl);
    e.stall_chk = known;
    e.st        = s;
    if (!is1(v.rst_n)) begin
      e.st = '0;
    end else if (fl || (!hd && hazard) || (!hd && !is1(v.id_valid))) begin
      e.st.valid = 1'b0;
      e.st.ctrl  = 10'd0;
    end else if (!hd) begin
      e.st.valid = 1'b1;
      e.st.ctrl  = {is1(v.regds) & is1(v.urw), is1(v.branch), is1(v.mread),
                    is1(v.mtor) & is1(v.urw), is1(v.aop[2]), is1(v.aop[1]), is1(v.aop[0]),
                    is1(v.mwrite), is1(v.alusrc), is1(v.urw)};
      e.st.pc4 = v.pc4; e.st.rsd = v.rsd; e.st.rtd = v.rtd; e.st.imm = v.imm;
      e.st.rs  = v.rs;  e.st.rt  = v.rt;  e.st.rd  = v.rd;
    end
    if (is1(v.rst_n) && hazard && !fl && !hd && s.cnt != CNT_MAX) e.st.cnt = s.cnt + 1'b1;
    e.data_chk = e.st.valid | ~is1(v.rst_n);
    return e;
  endfunction

  function automatic in_t instr(input logic [2:0] aop, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
    in_t v = '0;
    v.rst_n = 1'b1; v.id_valid = 1'b1; v.aop = aop;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.pc4 = $urandom; v.rsd = $urandom; v.rtd = $urandom; v.imm = $urandom;
    case (aop)
      3'b000:  begin v.mread = 1'b1; v.mtor = 1'b1; v.alusrc = 1'b1; v.urw = 1'b1; end
      3'b001:  v.branch = 1'b1;
      3'b010:  begin v.regds = 1'b1; v.urw = 1'b1; end
      3'b111:  begin v.mwrite = 1'b1; v.alusrc = 1'b1; end
      default: begin v.alusrc = 1'b1; v.urw = 1'b1; end
    endcase
    return v;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0:       r = 5'd0;
      1:       r = 5'd8;
      2:       r = 5'd9;
      default: r = 5'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  function automatic in_t rnd();
    in_t v;
    v = instr(3'($urandom_range(0, 7)), pick_reg(), pick_reg(), pick_reg());
    {v.regds, v.branch, v.mread, v.mtor, v.mwrite, v.alusrc, v.urw} = 7'($urandom);
    v.id_valid = ($urandom_range(0, 9) < 8);
    v.flush    = ($urandom_range(0, 9) == 0);
    v.hold     = ($urandom_range(0, 6) == 0);
    v.rst_n    = ($urandom_range(0, 49) != 0);
    return v;
  endfunction

  task automatic drive(input in_t v);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; id_valid_i = v.id_valid; flush_i = v.flush; hold_i = v.hold;
    RegDs_i = v.regds; Branch_i = v.branch; MRead_i = v.mread; MtoR_i = v.mtor;
    MWrite_i = v.mwrite; ALUsrc_i = v.alusrc; Urw_i = v.urw; AOp_i = v.aop;
    pc4_i = v.pc4; rs_data_i = v.rsd; rt_data_i = v.rtd; imm_i = v.imm;
    rs_i = v.rs; rt_i = v.rt; rd_i = v.rd;
    e = predict(model_st, model_known, v);
    exp_q.push_back(e);
    model_st = e.st;
    model_known = model_known | ~is1(v.rst_n);
  endtask

  // Monitor: stall_o mid-cycle, registered outputs just after each edge.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2 s = stall_o;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("no_expectation", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.stall_chk) chk("stall_o", {31'd0, s}, {31'd0, e.stall});
        chk("ex_valid_o", {31'd0, ex_valid_o}, {31'd0, e.st.valid});
        chk("ctrl", {22'd0, RegDs_o, Branch_o, MRead_o, MtoR_o, AOp_o, MWrite_o, ALUsrc_o, Urw_o},
            {22'd0, e.st.ctrl});
        chk("stall_cnt_o", 32'(stall_cnt_o), 32'(e.st.cnt));
        if (e.data_chk) begin
          chk("pc4_o", pc4_o, e.st.pc4);
          chk("rs_data_o", rs_data_o, e.st.rsd);
          chk("rt_data_o", rt_data_o, e.st.rtd);
          chk("imm_o", imm_o, e.st.imm);
          chk("fields", {17'd0, rs_o, rt_o, rd_o}, {17'd0, e.st.rs, e.st.rt, e.st.rd});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t v;
    v = rnd(); v.rst_n = 1'b0; drive(v);
    v = rnd(); v.rst_n = 1'b0; drive(v);
    v = instr(3'b011, 5'd1, 5'd2, 5'd0); v.imm = 32'd5; drive(v);
    // LW $8 then dependent ADD: one bubble, then the ADD is captured.
    v = instr(3'b000, 5'd1, 5'd8, 5'd0); drive(v);
    v = instr(3'b010, 5'd8, 5'd9, 5'd10); drive(v); drive(v);
    // No false hazards: $0 target, and rt of an ADDI is not a source.
    v = instr(3'b000, 5'd1, 5'd0, 5'd0); drive(v);
    v = instr(3'b010, 5'd0, 5'd2, 5'd3); drive(v);
    v = instr(3'b000, 5'd1, 5'd8, 5'd0); drive(v);
    v = instr(3'b011, 5'd9, 5'd8, 5'd0); drive(v);
    // Flush with hold and a hazard pending.
    v = instr(3'b000, 5'd1, 5'd8, 5'd0); drive(v);
    v = instr(3'b010, 5'd8, 5'd9, 5'd10); v.flush = 1'b1; v.hold = 1'b1; drive(v);
    v.flush = 1'b0; v.hold = 1'b0; drive(v);
    // Hold for three cycles with changing inputs, then release.
    v = instr(3'b010, 5'd2, 5'd3, 5'd4); drive(v);
    for (int i = 0; i < 3; i++) begin
      v = instr(3'($urandom_range(0, 7)), pick_reg(), pick_reg(), pick_reg());
      v.hold = 1'b1; drive(v);
    end
    v = instr(3'b010, 5'd5, 5'd6, 5'd7); drive(v);
    // SW with unknown write-back selects.
    v = instr(3'b111, 5'd2, 5'd3, 5'd0); v.regds = 1'bx; v.mtor = 1'bx; drive(v);
    v = instr(3'b010, 5'd1, 5'd2, 5'd3); drive(v);
    for (int i = 0; i < 2000; i++) begin
      v = rnd(); drive(v);
    end
    v = instr(3'b010, 5'd1, 5'd2, 5'd3); v.rst_n = 1'b0; drive(v);
    // Back-to-back dependent loads: one stall every two cycles until saturation.
    for (int i = 0; i < 600; i++) begin
      v = instr(3'b000, 5'd8, 5'd8, 5'd0); drive(v);
    end
    @(posedge clk);
    #3;
    chk("saturated_cnt", 32'(stall_cnt_o), 32'(CNT_MAX));
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
